// File: rtl/fetch_stat_unit.sv
// Fetch/status datapath: PC, IR and status register with an
// instruction-memory fetch handshake and a bounded wait on IMEM_ACK.
module fetch_stat_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       TIMEOUT  = 15
) (
   input  logic              CLK,
   input  logic              RST_F,
   input  logic              PC_RST,
   input  logic              PC_WRITE,
   input  logic              PC_SEL,
   input  logic              BR_SEL,
   input  logic              STAT_WE,
   input  logic [3:0]        ALU_FLAGS,
   input  logic              IMEM_ACK,
   input  logic [31:0]       IMEM_RDATA,
   output logic              IMEM_REQ,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic [3:0]        OPCODE,
   output logic [3:0]        MM,
   output logic [3:0]        RD,
   output logic [3:0]        RS,
   output logic [15:0]       IMM,
   output logic [3:0]        STAT,
   output logic [ADDR_W-1:0] PC_OUT,
   output logic              FETCH_BUSY,
   output logic              FETCH_ERR
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [31:0] IR_HLT = 32'hF000_0000;

   typedef enum logic {
      S_IDLE,
      S_FETCH
   } state_t;

   state_t            st_q, st_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [3:0]        stat_q, stat_d;
   logic              req_q, req_d;
   logic              err_q, err_d;
   logic [CW-1:0]     tmo_q, tmo_d;
   logic              pw_q, pw_d;

   logic              pw_rise;
   logic [ADDR_W-1:0] tgt_abs;
   logic [ADDR_W-1:0] tgt_rel;

   assign pw_rise = PC_WRITE & ~pw_q;
   assign tgt_abs = ADDR_W'(ir_q[15:0]);
   assign tgt_rel = pc_q + ADDR_W'($signed(ir_q[15:0]));

   always_comb begin
      st_d   = st_q;
      pc_d   = pc_q;
      ir_d   = ir_q;
      stat_d = stat_q;
      req_d  = req_q;
      err_d  = err_q;
      tmo_d  = tmo_q;
      pw_d   = PC_WRITE;

      if (STAT_WE) begin
         stat_d = ALU_FLAGS;
      end

      // PC_RST overrides the fetch machine; STAT and the sticky error survive
      if (PC_RST) begin
         st_d  = S_IDLE;
         pc_d  = RESET_PC;
         ir_d  = '0;
         req_d = 1'b0;
         tmo_d = '0;
      end else begin
         unique case (st_q)
            S_IDLE: begin
               if (pw_rise) begin
                  unique case (1'b1)
                     !PC_SEL: begin
                        st_d  = S_FETCH;
                        req_d = 1'b1;
                        tmo_d = '0;
                     end
                     PC_SEL && BR_SEL:  pc_d = tgt_abs;
                     PC_SEL && !BR_SEL: pc_d = tgt_rel;
                     default: ;
                  endcase
               end
            end
            S_FETCH: begin
               if (IMEM_ACK) begin
                  st_d  = S_IDLE;
                  ir_d  = IMEM_RDATA;
                  pc_d  = pc_q + ADDR_W'(1);
                  req_d = 1'b0;
                  tmo_d = '0;
               end else if (tmo_q == TMO_LAST) begin
                  st_d  = S_IDLE;
                  ir_d  = IR_HLT;
                  err_d = 1'b1;
                  req_d = 1'b0;
                  tmo_d = '0;
               end else begin
                  tmo_d = tmo_q + CW'(1);
               end
            end
            default: begin
               st_d  = S_IDLE;
               req_d = 1'b0;
               tmo_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         st_q   <= S_IDLE;
         pc_q   <= RESET_PC;
         ir_q   <= '0;
         stat_q <= '0;
         req_q  <= 1'b0;
         err_q  <= 1'b0;
         tmo_q  <= '0;
         pw_q   <= 1'b0;
      end else begin
         st_q   <= st_d;
         pc_q   <= pc_d;
         ir_q   <= ir_d;
         stat_q <= stat_d;
         req_q  <= req_d;
         err_q  <= err_d;
         tmo_q  <= tmo_d;
         pw_q   <= pw_d;
      end
   end

   assign IMEM_REQ   = req_q;
   assign IMEM_ADDR  = pc_q;
   assign PC_OUT     = pc_q;
   assign OPCODE     = ir_q[31:28];
   assign MM         = ir_q[27:24];
   assign RD         = ir_q[23:20];
   assign RS         = ir_q[19:16];
   assign IMM        = ir_q[15:0];
   assign STAT       = stat_q;
   assign FETCH_BUSY = (st_q == S_FETCH);
   assign FETCH_ERR  = err_q;

endmodule

// File: doc/fetch_stat_unit.md
Name: fetch_stat_unit

Overview:
- Datapath-side counterpart of the multicycle control FSM: consumes PC_WRITE/PC_SEL/BR_SEL/PC_RST and produces the OPCODE, MM and STAT fields that the FSM decodes.
- Holds PC, IR and the status register; runs the instruction-memory fetch handshake.
- Sits between the control FSM, the instruction memory and the ALU flag outputs.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- RESET_PC, 0, PC value after RST_F or PC_RST.
- TIMEOUT, 15, maximum cycles to wait for IMEM_ACK before aborting a fetch.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_F  in  1  asynchronous active-low reset.
- PC_RST  in  1  synchronous PC reset request from the control FSM.
- PC_WRITE  in  1  PC update request; may be held high for several cycles.
- PC_SEL  in  1  0 = sequential fetch, 1 = load branch target.
- BR_SEL  in  1  1 = absolute target, 0 = PC-relative target.
- STAT_WE  in  1  status register write enable.
- ALU_FLAGS  in  4  {N,Z,C,V} from the ALU.
- IMEM_ACK  in  1  instruction memory data valid.
- IMEM_RDATA  in  32  instruction word.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  ADDR_W  fetch address (PC).
- OPCODE  out  4  IR[31:28].
- MM  out  4  IR[27:24].
- RD  out  4  IR[23:20].
- RS  out  4  IR[19:16].
- IMM  out  16  IR[15:0].
- STAT  out  4  status register.
- PC_OUT  out  ADDR_W  current PC.
- FETCH_BUSY  out  1  high while in the FETCH state.
- FETCH_ERR  out  1  sticky flag, set on fetch timeout.

Behaviour:
- Reset (RST_F low, asynchronous):
  - PC = RESET_PC; IR = 0 (so OPCODE = noop); STAT = 0.
  - FSM = IDLE; IMEM_REQ = 0; FETCH_ERR = 0; timeout counter = 0; edge-detect register = 0.
- Edge detect: a PC_WRITE request is the first cycle PC_WRITE=1 after a cycle with PC_WRITE=0. A held level acts once.
- FSM states IDLE and FETCH.
- IDLE, on a request:
  - PC_SEL=0: go to FETCH next edge; IMEM_REQ=1 and IMEM_ADDR=PC from the next cycle.
  - PC_SEL=1, BR_SEL=1: PC <= IMM[ADDR_W-1:0], zero-extended. Stay IDLE; no memory access.
  - PC_SEL=1, BR_SEL=0: PC <= PC + sign-extended IMM, modulo 2^ADDR_W. PC already points past the branch instruction. Stay IDLE.
- FETCH:
  - IMEM_REQ held high and IMEM_ADDR stable until acknowledged.
  - On the edge with IMEM_ACK=1: IR <= IMEM_RDATA, PC <= PC+1 (wraps at 2^ADDR_W), IMEM_REQ <= 0, go to IDLE.
  - Latency: minimum 2 edges from request to IR update.
  - IMEM_ACK is ignored in IDLE.
- Timeout:
  - The counter counts FETCH cycles without an ack.
  - When it reaches TIMEOUT: abort, IR <= 32'hF000_0000 (hlt, stops the FSM), FETCH_ERR <= 1, PC unchanged, go to IDLE.
  - An ack in the same cycle as the timeout wins: normal load, no error.
- PC_WRITE requests arriving while in FETCH are dropped, not queued.
- PC_RST=1 (synchronous, highest priority after RST_F):
  - PC = RESET_PC, IR = 0, FSM = IDLE, IMEM_REQ = 0.
  - Any ack in that cycle is discarded; PC_WRITE in that cycle is ignored.
  - STAT and FETCH_ERR are unchanged.
- Status register:
  - STAT_WE=1: STAT <= ALU_FLAGS at the edge, independent of FSM state and PC_RST.
  - STAT is visible the cycle after the write. No bypass.
- Output timing: OPCODE/MM/RD/RS/IMM are combinational slices of IR and change only on the IR-load edge.
- FETCH_ERR clears only on RST_F.

Test Plan:
- Reset, then PC_WRITE=1 held 3 cycles with PC_SEL=0; memory acks 2 cycles after REQ with 32'h8_0_1_2_0005 -> exactly one fetch at addr 0; OPCODE=8, MM=0, RD=1, IMM=5; PC=1.
- PC=1, IMM=16'h0040, PC_SEL=1, BR_SEL=1, PC_WRITE pulse -> PC=0x0040 next edge; IMEM_REQ stays 0.
- PC=0x0041, IMM=16'hFFFE, BR_SEL=0 -> PC=0x003F. PC=16'hFFFF sequential fetch -> PC wraps to 0x0000.
- Fetch with no ack for 15 cycles -> OPCODE=15 (hlt), FETCH_ERR=1, PC unchanged. Ack arriving exactly at cycle 15 -> normal load, FETCH_ERR=0.
- PC_RST asserted in the same cycle as IMEM_ACK -> PC=RESET_PC, OPCODE=0, IMEM_REQ=0, data discarded. STAT_WE in that cycle with ALU_FLAGS=4'b0100 -> STAT=4'b0100.
- RST_F pulsed low mid-FETCH, between clock edges -> IMEM_REQ drops immediately; PC=0, STAT=0, FETCH_ERR=0.
